// File: rtl/jk_pkg.sv
// Shared JK flip-flop encodings and the excitation helper used by the counter.
package jk_pkg;

   // {J,K} input encodings
   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_RST  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TGL  = 2'b11;

   // Returns {J,K} that moves a cell from q to n without ever using toggle.
   function automatic logic [1:0] jk_excite(input logic q, input logic n);
      return {~q & n, q & ~n};
   endfunction

endpackage

// File: rtl/jk_mod_counter_if.sv
// Control and status bundle of the modulo-N JK counter.
interface jk_mod_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qb;
   logic             tc;
   logic             wrap;
   logic             load_err;

   modport master (
      output en, up, load, din,
      input  q, qb, tc, wrap, load_err
   );

   modport slave (
      input  en, up, load, din,
      output q, qb, tc, wrap, load_err
   );
endinterface

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-high reset to q=0.
module jk_cell
   import jk_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q,
   output logic qb
);

   logic state_q;

   // JK state update; reset clears the cell without a clock edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= 1'b0;
      end else begin
         case ({j, k})
            JK_HOLD: state_q <= state_q;
            JK_RST:  state_q <= 1'b0;
            JK_SET:  state_q <= 1'b1;
            JK_TGL:  state_q <= ~state_q;
            default: state_q <= state_q;
         endcase
      end
   end

   assign q  = state_q;
   assign qb = ~state_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter whose state lives in WIDTH JK cells; the top level
// computes the next count and converts it to per-cell J/K excitation.
module jk_mod_counter
   import jk_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input logic             clk,
   input logic             rst,
   jk_mod_counter_if.slave bus
);

   // Reject parameter combinations the count range cannot represent
   if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
      $error("jk_mod_counter: WIDTH=%0d MODULUS=%0d out of range", WIDTH, MODULUS);
   end

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
   localparam logic [31:0]      MOD_U = 32'(MODULUS);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_qb;
   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] j_vec;
   logic [WIDTH-1:0] k_vec;
   logic             wrap_d;
   logic             wrap_q;
   logic             load_err_d;
   logic             load_err_q;

   // Next-count decode: load beats enable; counts at or past the top wrap to 0
   always_comb begin
      cnt_d      = cnt_q;
      wrap_d     = 1'b0;
      load_err_d = 1'b0;
      if (bus.load) begin
         if (32'(bus.din) >= MOD_U) begin
            cnt_d      = '0;
            load_err_d = 1'b1;
         end else begin
            cnt_d = bus.din;
         end
      end else if (bus.en) begin
         if (bus.up) begin
            if (cnt_q >= MAX_V) begin
               cnt_d  = '0;
               wrap_d = 1'b1;
            end else begin
               cnt_d = cnt_q + WIDTH'(1);
            end
         end else begin
            if (cnt_q == '0) begin
               cnt_d  = MAX_V;
               wrap_d = 1'b1;
            end else begin
               cnt_d = cnt_q - WIDTH'(1);
            end
         end
      end
   end

   // One JK cell per bit, excited only toward the bit's next value
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      assign {j_vec[i], k_vec[i]} = jk_excite(cnt_q[i], cnt_d[i]);

      jk_cell u_cell (
         .clk (clk),
         .rst (rst),
         .j   (j_vec[i]),
         .k   (k_vec[i]),
         .q   (cnt_q[i]),
         .qb  (cnt_qb[i])
      );
   end

   // Status pulses aligned with the count they describe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrap_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         wrap_q     <= wrap_d;
         load_err_q <= load_err_d;
      end
   end

   assign bus.q        = cnt_q;
   assign bus.qb       = cnt_qb;
   assign bus.tc       = bus.up ? (cnt_q == MAX_V) : (cnt_q == '0);
   assign bus.wrap     = wrap_q;
   assign bus.load_err = load_err_q;

endmodule
